// File: rtl/lm_scheduler.sv
// LED FIFO write scheduler: arbitrates requesters (bit 0 = error source, strict priority,
// the rest round-robin), issues one FIFO write per grant, then idles for HOLD_CYCLES.
module lm_scheduler #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     fifo_full,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     busy,
    output logic [2:0]               grant_id
);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [2:0] LAST      = 3'(NUM_REQ - 1);
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           rr_q, rr_d;
    logic [2:0]           grant_q, grant_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic [7:0]           req_ext;
    logic [WIDTH-1:0]     slice [8];
    logic [7:0]           onehot;
    logic [2:0]           win, idx;
    logic                 found;

    // Arbiter: requests and patterns widened to 8 entries so a 3-bit index is always legal.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        for (int i = 0; i < 8; i++) slice[i] = '0;
        for (int i = 0; i < NUM_REQ; i++) slice[i] = req_data[i*WIDTH +: WIDTH];
        win   = '0;
        found = 1'b0;
        idx   = (rr_q >= LAST) ? 3'd1 : rr_q + 3'd1;
        if (req_ext[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                if (!found && req_ext[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
                idx = (idx == LAST) ? 3'd1 : idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (found && !fifo_full) begin
                    state_d   = WRITE;
                    grant_d   = win;
                    wr_data_d = slice[win];
                    if (win != 3'd0) rr_d = win;
                end
            end
            WRITE: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        wr_en_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        onehot  = 8'd1 << grant_d;
        ack_d   = wr_en_d ? onehot[NUM_REQ-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign ack      = ack_q;

endmodule
